// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl : stall/flush sequencer for the 5-stage RV32 pipeline
// with data-memory handshake and memory-timeout trap.  Revision: 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int DMEM_TIMEOUT = 64,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [4:0]             id_ex_rd,
  input  logic                   id_ex_mem_read,
  input  logic                   ex_branch_taken,
  input  logic                   ex_mem_mem_read,
  input  logic                   ex_mem_mem_write,
  input  logic                   dmem_ready,
  output logic                   dmem_req,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_en,
  output logic                   id_ex_flush,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en,
  output logic                   mem_wb_flush,
  output logic                   bus_err,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] C_ST_RUN   = 2'd0;
  localparam logic [1:0] C_ST_WAIT  = 2'd1;
  localparam logic [1:0] C_ST_ERROR = 2'd2;

  localparam int WAIT_W = (DMEM_TIMEOUT < 2) ? 2 : $clog2(DMEM_TIMEOUT + 1) + 1;
  localparam logic [WAIT_W-1:0]      C_TIMEOUT  = WAIT_W'(DMEM_TIMEOUT);
  localparam logic                   C_TO_EN    = (DMEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0]      C_WAIT_MAX = {WAIT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] C_CNT_MAX  = {STALL_CNT_W{1'b1}};

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [WAIT_W-1:0]      r_wait_cnt;
  logic [WAIT_W-1:0]      w_wait_nxt;
  logic                   r_bus_err;
  logic [STALL_CNT_W-1:0] r_stall_cycles;

  logic w_mem_acc;
  logic w_dmem_req;
  logic w_mem_stall;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;

  assign w_mem_acc   = ex_mem_mem_read | ex_mem_mem_write;
  assign w_dmem_req  = rstn & (r_state != C_ST_ERROR) & w_mem_acc;
  assign w_mem_stall = w_dmem_req & ~dmem_ready;
  assign w_rs1_hit   = id_uses_rs1 & (id_rs1 == id_ex_rd);
  assign w_rs2_hit   = id_uses_rs2 & (id_rs2 == id_ex_rd);
  assign w_load_use  = id_ex_mem_read & (id_ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= C_ST_RUN;
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_state_nxt == C_ST_ERROR)
        r_bus_err <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      C_ST_RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = C_ST_WAIT;
          w_wait_nxt  = WAIT_W'(1);
        end
      end
      C_ST_WAIT: begin
        if (dmem_ready) begin
          w_state_nxt = C_ST_RUN;
          w_wait_nxt  = '0;
        end else if (C_TO_EN && (r_wait_cnt == C_TIMEOUT)) begin
          w_state_nxt = C_ST_ERROR;
        end else if (r_wait_cnt != C_WAIT_MAX) begin
          w_wait_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      C_ST_ERROR: begin
        w_state_nxt = C_ST_ERROR;
      end
      default: begin
        w_state_nxt = C_ST_RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Output logic: memory stall outranks branch squash, which outranks load-use
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rstn) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (r_state == C_ST_ERROR) begin
      pc_en = 1'b0;
    end else if (w_mem_stall) begin
      mem_wb_en    = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
    end else if (w_load_use) begin
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
    end
  end

  // Saturating count of frozen-PC cycles outside the trap state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cycles <= '0;
    end else if ((r_state != C_ST_ERROR) && !pc_en && (r_stall_cycles != C_CNT_MAX)) begin
      r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
    end
  end

  assign dmem_req     = w_dmem_req;
  assign bus_err      = r_bus_err;
  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// Testbench for pipeline_hazard_ctrl: vector table, directed multi-cycle
// sequences and randomized traffic against a reference model.
module tb_pipeline_hazard_ctrl;

  localparam int T = 4;

  // Output vector order: req,pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,memwb_en,memwb_fl,bus_err
  localparam logic [9:0] V_RST   = 10'b0_0_0_1_0_1_0_0_1_0;
  localparam logic [9:0] V_ERR   = 10'b0_0_0_0_0_0_0_0_0_1;
  localparam logic [9:0] V_IDLE  = 10'b0_1_1_0_1_0_1_1_0_0;
  localparam logic [9:0] V_REQ   = 10'b1_1_1_0_1_0_1_1_0_0;
  localparam logic [9:0] V_LU    = 10'b0_0_0_0_1_1_1_1_0_0;
  localparam logic [9:0] V_LUREQ = 10'b1_0_0_0_1_1_1_1_0_0;
  localparam logic [9:0] V_BR    = 10'b0_1_1_1_1_1_1_1_0_0;
  localparam logic [9:0] V_BRREQ = 10'b1_1_1_1_1_1_1_1_0_0;
  localparam logic [9:0] V_STALL = 10'b1_0_0_0_0_0_0_1_1_0;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       ld;
    logic       st;
    logic       rdy;
  } in_t;

  typedef struct {
    in_t        in;
    logic [9:0] exp;
    int         inc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  id_rs1, id_rs2, id_ex_rd;
  logic        id_uses_rs1, id_uses_rs2, id_ex_mem_read, ex_branch_taken;
  logic        ex_mem_mem_read, ex_mem_mem_write, dmem_ready;
  logic        dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, mem_wb_en, mem_wb_flush, bus_err;
  logic [31:0] stall_cycles;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint exp_cnt;
  vec_t   tbl [9];

  // Reference model state
  bit     m_trap;
  int     m_wait;
  longint m_stall;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DMEM_TIMEOUT(T), .STALL_CNT_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
    .bus_err(bus_err), .stall_cycles(stall_cycles)
  );

  task automatic drive(input in_t v);
    id_rs1           = v.rs1;
    id_rs2           = v.rs2;
    id_uses_rs1      = v.u1;
    id_uses_rs2      = v.u2;
    id_ex_rd         = v.rd;
    id_ex_mem_read   = v.mr;
    ex_branch_taken  = v.br;
    ex_mem_mem_read  = v.ld;
    ex_mem_mem_write = v.st;
    dmem_ready       = v.rdy;
  endtask

  task automatic check_vec(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, mem_wb_flush, bus_err};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cnt(input string name, input longint exp);
    n_tests++;
    if (stall_cycles !== exp[31:0]) begin
      n_fail++;
      $display("FAIL %s: stall_cycles got %0d expected %0d at %0t", name, stall_cycles, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, sample 1ns later (clock edge is 4ns away)
  task automatic cycle(input in_t v, input string name, input logic [9:0] exp);
    @(negedge clk);
    drive(v);
    #1;
    check_vec(name, exp);
    check_cnt({name, "_cnt"}, exp_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    drive('0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_cnt = 0;
  endtask

  // Reference model: expected outputs derived directly from the priority rules
  function automatic logic [9:0] model_out(input logic rn, input in_t v);
    logic req, lu;
    if (!rn) return V_RST;
    if (m_trap) return V_ERR;
    req = v.ld | v.st;
    lu  = v.mr && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    if (req && !v.rdy) return V_STALL;
    if (v.br) return {req, 9'b1_1_1_1_1_1_1_0_0};
    if (lu)   return {req, 9'b0_0_0_1_1_1_1_0_0};
    return {req, 9'b1_1_0_1_0_1_1_0_0};
  endfunction

  // m_wait counts how many cycles the pending access has already been refused
  task automatic model_step(input in_t v, input logic [9:0] o);
    logic req_stall;
    if (m_trap) return;
    if (!o[8]) m_stall++;
    req_stall = (v.ld | v.st) & ~v.rdy;
    if (m_wait == 0) begin
      if (req_stall) m_wait = 1;
    end else if (v.rdy) begin
      m_wait = 0;
    end else if (m_wait == T) begin
      m_trap = 1'b1;
    end else begin
      m_wait++;
    end
  endtask

  initial begin
    in_t v;
    in_t lu5;
    logic [9:0] e;

    rstn = 1'b0;
    drive('0);
    exp_cnt = 0;

    // Reset with memory access and load-use asserted
    lu5 = '0; lu5.mr = 1; lu5.rd = 5'd5; lu5.rs2 = 5'd5; lu5.u2 = 1; lu5.ld = 1;
    for (int i = 0; i < 3; i++) cycle(lu5, "reset_hold", V_RST);
    @(negedge clk);
    rstn = 1'b1;
    drive('0);
    #1;
    check_vec("reset_release", V_IDLE);
    check_cnt("reset_release_cnt", 0);

    // Single-cycle vector table (FSM stays in RUN throughout)
    tbl[0].in = '0;  tbl[0].exp = V_IDLE; tbl[0].inc = 0;
    tbl[1].in = '0;  tbl[1].in.mr = 1; tbl[1].in.rd = 5; tbl[1].in.rs2 = 5; tbl[1].in.u2 = 1;
    tbl[1].exp = V_LU; tbl[1].inc = 1;
    tbl[2].in = tbl[1].in; tbl[2].in.rd = 0; tbl[2].in.rs2 = 0; tbl[2].exp = V_IDLE; tbl[2].inc = 0;
    tbl[3].in = '0;  tbl[3].in.mr = 1; tbl[3].in.rd = 7; tbl[3].in.rs1 = 7;
    tbl[3].exp = V_IDLE; tbl[3].inc = 0;
    tbl[4].in = tbl[3].in; tbl[4].in.u1 = 1; tbl[4].exp = V_LU; tbl[4].inc = 1;
    tbl[5].in = tbl[1].in; tbl[5].in.br = 1; tbl[5].exp = V_BR; tbl[5].inc = 0;
    tbl[6].in = '0;  tbl[6].in.ld = 1; tbl[6].in.rdy = 1; tbl[6].exp = V_REQ; tbl[6].inc = 0;
    tbl[7].in = tbl[4].in; tbl[7].in.st = 1; tbl[7].in.rdy = 1; tbl[7].exp = V_LUREQ; tbl[7].inc = 1;
    tbl[8].in = tbl[4].in; tbl[8].in.mr = 0; tbl[8].exp = V_IDLE; tbl[8].inc = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].in, $sformatf("table%0d", i), tbl[i].exp);
      exp_cnt += tbl[i].inc;
    end
    cycle('0, "table_end", V_IDLE);

    // Multi-cycle load: three refused cycles then completion
    v = '0; v.ld = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(v, "mc_load_stall", V_STALL);
      exp_cnt++;
    end
    v.rdy = 1;
    cycle(v, "mc_load_done", V_REQ);
    cycle('0, "mc_load_after", V_IDLE);
    cycle(v, "zero_wait", V_REQ);
    cycle('0, "zero_wait_after", V_IDLE);

    // Branch held in EX across a two-cycle memory stall
    v = '0; v.ld = 1; v.br = 1;
    for (int i = 0; i < 2; i++) begin
      cycle(v, "stall_vs_branch", V_STALL);
      exp_cnt++;
    end
    v.rdy = 1;
    cycle(v, "branch_after_stall", V_BRREQ);
    cycle('0, "branch_after_idle", V_IDLE);

    // Timeout trap
    do_reset();
    v = '0; v.ld = 1;
    for (int i = 0; i < T + 1; i++) begin
      cycle(v, "timeout_stall", V_STALL);
      exp_cnt++;
    end
    for (int i = 0; i < 3; i++) cycle(v, "timeout_error", V_ERR);
    v.rdy = 1;
    cycle(v, "error_absorbing", V_ERR);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    exp_cnt = 0;
    check_vec("error_async_clear", V_RST);
    check_cnt("error_async_clear_cnt", 0);
    @(negedge clk);
    rstn = 1'b1;
    drive('0);
    #1;
    check_vec("after_error_reset", V_IDLE);

    // Randomized traffic against the reference model
    m_trap = 0; m_wait = 0; m_stall = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rstn  = !((c % 97) == 50);
      v.rs1 = 5'($urandom_range(0, 3));
      v.rs2 = 5'($urandom_range(0, 3));
      v.u1  = 1'($urandom_range(0, 1));
      v.u2  = 1'($urandom_range(0, 1));
      v.rd  = 5'($urandom_range(0, 3));
      v.mr  = ($urandom_range(0, 9) < 4);
      v.br  = ($urandom_range(0, 9) < 2);
      v.ld  = ($urandom_range(0, 9) < 3);
      v.st  = ($urandom_range(0, 9) < 2);
      v.rdy = ($urandom_range(0, 9) < 6);
      drive(v);
      if (!rstn) begin
        m_trap = 0; m_wait = 0; m_stall = 0;
      end
      #1;
      e = model_out(rstn, v);
      check_vec("random", e);
      check_cnt("random_cnt", m_stall);
      if (rstn) model_step(v, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
